// File: rtl/uart_tx_peri.sv
// uart_tx_peri: memory-mapped 8N1 UART transmitter with a TX FIFO.
//
// The CPU writes bytes to TXDATA; they queue in a FIFO and a baud-timed FSM
// shifts them out LSB first on uart_tx. The FIFO depth and the reset baud
// divisor are parameters.
//
// Register map (byte offsets):
//   0x00 TXDATA  W : bmask[0] pushes w_data[7:0]; reads 0
//   0x04 STATUS  R : [0] busy [1] full [2] empty [3] overflow [11:8] count
//                W : writing 1 to bit 3 (bmask[0]) clears overflow
//   0x08 BAUDDIV RW: [15:0], byte lanes follow bmask[1:0]
//   0x0C CTRL    RW: [0] EN, [1] PEN (parity build only)
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, enabled per frame by CTRL[1].

module uart_tx_peri #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [31:0] w_data,
    input  logic        wr_en,
    input  logic [3:0]  bmask,
    output logic [31:0] rd_data,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] ADDR_TXDATA  = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_BAUDDIV = 8'h08;
    localparam logic [7:0] ADDR_CTRL    = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_txdata;
    logic wr_status;
    logic wr_baud;
    logic wr_ctrl;

    assign wr_txdata = wr_en && (addr == ADDR_TXDATA);
    assign wr_status = wr_en && (addr == ADDR_STATUS);
    assign wr_baud   = wr_en && (addr == ADDR_BAUDDIV);
    assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);

    // Upper data lanes and byte enables 2/3 select nothing in this block.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{w_data[31:16], bmask[3:2]};

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic [15:0] baud_div;
    logic        en;
    logic        overflow;
`ifdef UART_TX_PARITY_EN
    logic        pen;
`endif

    // FIFO state, declared here because overflow depends on it.
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             push_req;
    logic             push_ok;
    logic             pop;

    // Software-visible configuration and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_div <= DEFAULT_DIV;
            en       <= 1'b1;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            pen      <= 1'b1;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            if (wr_baud && bmask[0]) baud_div[7:0]  <= w_data[7:0];
            if (wr_baud && bmask[1]) baud_div[15:8] <= w_data[15:8];
            if (wr_ctrl && bmask[0]) begin
                en  <= w_data[0];
`ifdef UART_TX_PARITY_EN
                pen <= w_data[1];
`endif
            end
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_status && bmask[0] && w_data[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // Full is judged on the pre-edge count, so a push that meets a pop
    // while full is still dropped; there is no bypass to the FSM either.
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];
    assign push_req   = wr_txdata && bmask[0];
    assign push_ok    = push_req && !fifo_full;

    // Byte storage: written on accepted pushes only.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only ever read
        // behind a non-zero count, so their power-up contents are irrelevant.
        if (push_ok) begin
            fifo_mem[wr_ptr] <= w_data[7:0];
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [15:0] div_lat;
    logic [15:0] baud_cnt;
    logic        baud_tick;
    logic        baud_clr;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        shift_en;
    logic        tx_next;
    logic        can_start;
`ifdef UART_TX_PARITY_EN
    logic        pen_lat;
    logic        parity_bit;
`endif

    assign baud_tick = (baud_cnt == div_lat - 16'd1);
    assign can_start = en && !fifo_empty;
    assign tx_busy   = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, FIFO pop and the next serial line level.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        pop        = 1'b0;
        baud_clr   = 1'b0;
        shift_en   = 1'b0;
        tx_next    = uart_tx;

        case (state)
            ST_IDLE: begin
                tx_next  = 1'b1;
                baud_clr = 1'b1;
                if (can_start) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    baud_clr   = 1'b1;
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    baud_clr = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        if (pen_lat) begin
                            state_next = ST_PARITY;
                            tx_next    = parity_bit;
                        end else
`endif
                        begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        shift_en = 1'b1;
                        tx_next  = shift_reg[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    baud_clr   = 1'b1;
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (baud_tick) begin
                    baud_clr = 1'b1;
                    // Chain straight into the next start bit when possible.
                    if (can_start) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // Bit timer, shift register and per-frame latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_tx    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            div_lat    <= 16'd1;
`ifdef UART_TX_PARITY_EN
            pen_lat    <= 1'b0;
            parity_bit <= 1'b0;
`endif
        end else begin
            uart_tx  <= tx_next;
            baud_cnt <= baud_clr ? 16'd0 : baud_cnt + 16'd1;
            if (pop) begin
                // Divisor and parity mode are frozen for the whole frame;
                // a zero divisor runs at one cycle per bit.
                shift_reg  <= fifo_head;
                bit_cnt    <= '0;
                div_lat    <= (baud_div == 16'd0) ? 16'd1 : baud_div;
`ifdef UART_TX_PARITY_EN
                pen_lat    <= pen;
                parity_bit <= ^fifo_head;
`endif
            end else if (shift_en) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, no wait state)
    // ------------------------------------------------------------------
    // Register read-back for the current address.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_STATUS: begin
                rd_data[0]    = tx_busy;
                rd_data[1]    = fifo_full;
                rd_data[2]    = fifo_empty;
                rd_data[3]    = overflow;
                rd_data[11:8] = 4'(count);
            end
            ADDR_BAUDDIV: begin
                rd_data[15:0] = baud_div;
            end
            ADDR_CTRL: begin
                rd_data[0] = en;
`ifdef UART_TX_PARITY_EN
                rd_data[1] = pen;
`endif
            end
            default: begin
                rd_data = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_peri.sv
// tb_uart_tx_peri: self-checking bench for uart_tx_peri.
// Stimulus queues expected bytes; an independent monitor decodes each frame
// off uart_tx using the divisor/parity mode the bench last programmed and
// compares it with the queue head. Honours UART_TX_PARITY_EN.

module tb_uart_tx_peri;

    localparam int          FIFO_DEPTH  = 8;
    localparam logic [15:0] DEFAULT_DIV = 16'd434;
`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
    localparam int FRAME_BITS = 11;
`else
    localparam bit HAS_PARITY = 1'b0;
    localparam int FRAME_BITS = 10;
`endif

    localparam logic [7:0] A_TXDATA = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_BAUD   = 8'h08;
    localparam logic [7:0] A_CTRL   = 8'h0C;
    localparam logic [7:0] A_BAD    = 8'h10;

    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic [31:0] w_data;
    logic        wr_en;
    logic [3:0]  bmask;
    logic [31:0] rd_data;
    logic        uart_tx;
    logic        tx_busy;

    uart_tx_peri #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .w_data (w_data),
        .wr_en  (wr_en),
        .bmask  (bmask),
        .rd_data(rd_data),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard and reference-model state.
    logic [7:0] exp_q[$];
    int         start_times[$];
    int         shadow_div;
    bit         shadow_pen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Call in the low clock phase; consecutive calls give back-to-back writes.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        addr   = a;
        w_data = d;
        bmask  = m;
        wr_en  = 1'b1;
        @(negedge clk);
        wr_en  = 1'b0;
        bmask  = 4'h0;
    endtask

    task automatic check_reg(input logic [7:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, rd_data, exp);
        addr = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_sent);
        if (expect_sent) exp_q.push_back(b);
        bus_write(A_TXDATA, {24'($urandom()), b}, 4'h1);
    endtask

    task automatic set_div(input int d);
        bus_write(A_BAUD, 32'(d), 4'h3);
        shadow_div = d;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size() == 0 && !tx_busy), 32'd1);
    endtask

    // Monitor: decode each frame from the line and compare with the queue.
    initial begin : monitor
        logic        prev;
        logic [10:0] bits;
        logic [7:0]  e;
        logic [7:0]  rx;
        logic        rxpar;
        int          div;
        int          nb;
        int          bad;
        bit          aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else if (prev && !uart_tx) begin
                start_times.push_back(cycle);
                div = (shadow_div == 0) ? 1 : shadow_div;
                nb  = (HAS_PARITY && shadow_pen) ? 11 : 10;
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                e = 8'h00;
                if (exp_q.size() != 0) e = exp_q.pop_front();
                bits      = '1;
                bits[0]   = 1'b0;
                bits[8:1] = e;
                if (nb == 11) bits[9] = ^e;
                bad     = 0;
                rx      = 8'h00;
                rxpar   = 1'b0;
                aborted = 1'b0;
                for (int s = 0; s < nb && !aborted; s++) begin
                    for (int c = 0; c < div && !aborted; c++) begin
                        if (s != 0 || c != 0) @(negedge clk);
                        if (!rst) begin
                            aborted = 1'b1;
                        end else begin
                            if (uart_tx !== bits[s]) bad++;
                            if (c == div / 2 && s >= 1 && s <= 8) rx[s-1] = uart_tx;
                            if (c == div / 2 && s == 9 && nb == 11) rxpar = uart_tx;
                        end
                    end
                end
                if (!aborted) begin
                    check("frame_data", rx, e);
                    check("frame_shape_errors", bad, 0);
                    if (nb == 11) check("frame_parity", rxpar, ^e);
                end
                prev = aborted ? 1'b1 : uart_tx;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] got;
        bit         low_seen;
        int         n;
        bit         p;

        rst        = 1'b1;
        addr       = 8'h00;
        w_data     = 32'h0;
        wr_en      = 1'b0;
        bmask      = 4'h0;
        shadow_div = int'(DEFAULT_DIV);
        shadow_pen = HAS_PARITY;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_busy", tx_busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset values of every offset.
        check_reg(A_STATUS, 32'h0000_0004, "rst_status");
        check_reg(A_BAUD, 32'(DEFAULT_DIV), "rst_bauddiv");
        @(negedge clk);
        check_reg(A_CTRL, HAS_PARITY ? 32'h3 : 32'h1, "rst_ctrl");
        check_reg(A_TXDATA, 32'h0, "rst_txdata_reads0");
        check_reg(A_BAD, 32'h0, "rst_unmapped_reads0");
        check("idle_uart_tx", uart_tx, 1);
        @(negedge clk);

        // Byte lanes, unmapped writes, CTRL bits, masked TXDATA write.
        bus_write(A_BAUD, 32'hFFFF_1234, 4'b0010);
        check_reg(A_BAUD, 32'h12B2, "baud_lane1_only");
        bus_write(A_BAUD, 32'h0000_0077, 4'b0001);
        check_reg(A_BAUD, 32'h1277, "baud_lane0_only");
        bus_write(A_BAD, 32'hFFFF_FFFF, 4'hF);
        check_reg(A_BAUD, 32'h1277, "unmapped_write_ignored");
        bus_write(A_TXDATA, 32'h0000_0055, 4'b1110);
        check_reg(A_STATUS, 32'h4, "txdata_needs_lane0");
        bus_write(A_CTRL, 32'h2, 4'h1);
        check_reg(A_CTRL, HAS_PARITY ? 32'h2 : 32'h0, "ctrl_rw");
        bus_write(A_CTRL, 32'h3, 4'h1);
        shadow_pen = HAS_PARITY;
        set_div(4);

        // 0xA5 at divisor 4: latency, bit order, frame length.
        push_byte(8'hA5, 1'b1);
        check("latency_high_after_k", uart_tx, 1);
        @(negedge clk);
        check("latency_low_after_k1", uart_tx, 0);
        @(negedge clk);
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            got[i] = uart_tx;
        end
        check("a5_bits_lsb_first", got, 8'hA5);
        repeat (FRAME_BITS * 4 - 34) @(negedge clk);
        check("a5_busy_last_cycle", tx_busy, 1);
        check("a5_stop_high", uart_tx, 1);
        @(negedge clk);
        check("a5_idle_after_frame", tx_busy, 0);
        wait_drain(200, "a5_drain");

        // Nine back-to-back writes: first is popped at once, no overflow.
        for (int i = 0; i < 9; i++) push_byte(8'($urandom()), 1'b1);
        check_reg(A_STATUS, 32'h0000_0803, "burst9_status");
        // Push on the very edge the full FIFO pops: still dropped.
        repeat (FRAME_BITS * 4 - 8) @(negedge clk);
        push_byte(8'($urandom()), 1'b0);
        check_reg(A_STATUS, 32'h0000_0709, "full_push_pop_drops");
        bus_write(A_STATUS, 32'h8, 4'b1110);
        check_reg(A_STATUS, 32'h0000_0709, "ovf_clear_needs_lane0");
        bus_write(A_STATUS, 32'h8, 4'h1);
        check_reg(A_STATUS, 32'h0000_0701, "ovf_clear_a");
        wait_drain(9 * FRAME_BITS * 4 + 100, "burst9_drain");

        // Ten writes: one popped, eight fill the FIFO, the tenth overflows.
        for (int i = 0; i < 10; i++) push_byte(8'($urandom()), i < 9);
        check_reg(A_STATUS, 32'h0000_080B, "overflow_status");
        bus_write(A_STATUS, 32'h8, 4'h1);
        check_reg(A_STATUS, 32'h0000_0803, "ovf_clear_b");
        wait_drain(9 * FRAME_BITS * 4 + 100, "burst10_drain");

        // EN=0 holds the queue; EN=1 sends both frames with no gap.
        bus_write(A_CTRL, 32'({shadow_pen, 1'b0}), 4'h1);
        push_byte(8'($urandom()), 1'b1);
        push_byte(8'($urandom()), 1'b1);
        low_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!uart_tx) low_seen = 1'b1;
        end
        check("en0_line_idle", low_seen, 0);
        check("en0_not_busy", tx_busy, 0);
        check_reg(A_STATUS, 32'h0000_0200, "en0_status_count2");
        start_times.delete();
        bus_write(A_CTRL, 32'({shadow_pen, 1'b1}), 4'h1);
        wait_drain(3 * FRAME_BITS * 4 + 50, "en1_drain");
        check("en1_frame_count", start_times.size(), 2);
        if (start_times.size() == 2)
            check("en1_no_gap", start_times[1] - start_times[0], FRAME_BITS * 4);

        // BAUDDIV written mid-frame takes effect on the next frame.
        start_times.delete();
        push_byte(8'($urandom()), 1'b1);
        repeat (16) @(negedge clk);
        set_div(8);
        check_reg(A_BAUD, 32'h8, "baud_mid_frame_read");
        push_byte(8'($urandom()), 1'b1);
        wait_drain(FRAME_BITS * 12 + 50, "div_mid_drain");
        check("div_mid_frame_count", start_times.size(), 2);
        if (start_times.size() == 2)
            check("div_mid_first_len", start_times[1] - start_times[0], FRAME_BITS * 4);

        // Reset in the middle of a frame.
        push_byte(8'($urandom()), 1'b1);
        push_byte(8'($urandom()), 1'b1);
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_uart_tx", uart_tx, 1);
        check("midrst_busy", tx_busy, 0);
        check_reg(A_STATUS, 32'h4, "midrst_status");
        exp_q.delete();
        @(negedge clk);
        rst        = 1'b1;
        shadow_div = int'(DEFAULT_DIV);
        shadow_pen = HAS_PARITY;
        @(negedge clk);
        check_reg(A_BAUD, 32'(DEFAULT_DIV), "midrst_baud_default");
        low_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (!uart_tx || tx_busy) low_seen = 1'b1;
        end
        check("midrst_fifo_lost", low_seen, 0);
        set_div(4);

`ifdef UART_TX_PARITY_EN
        // 0x07 has odd weight, so even parity drives 1; frame is 44 cycles.
        push_byte(8'h07, 1'b1);
        repeat (38) @(negedge clk);
        check("parity_07_bit", uart_tx, 1);
        repeat (6) @(negedge clk);
        check("parity_busy_cycle44", tx_busy, 1);
        @(negedge clk);
        check("parity_idle_after44", tx_busy, 0);
        // PEN=0 falls back to 10-bit frames.
        bus_write(A_CTRL, 32'h1, 4'h1);
        shadow_pen = 1'b0;
        push_byte(8'($urandom()), 1'b1);
        repeat (40) @(negedge clk);
        check("nopar_busy_cycle40", tx_busy, 1);
        @(negedge clk);
        check("nopar_idle_after40", tx_busy, 0);
        wait_drain(100, "nopar_drain");
        bus_write(A_CTRL, 32'h3, 4'h1);
        shadow_pen = 1'b1;
`endif

        // Randomised frames: divisors including 0, bursts of 1..4 bytes.
        for (int it = 0; it < 25; it++) begin
            set_div($urandom_range(0, 6));
            if (HAS_PARITY) begin
                p = 1'($urandom_range(0, 1));
                bus_write(A_CTRL, 32'({p, 1'b1}), 4'h1);
                shadow_pen = p;
            end
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push_byte(8'($urandom()), 1'b1);
            wait_drain((n + 1) * 11 * 7 + 50, "rand_drain");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check_reg(A_STATUS, 32'h4, "final_status");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
